// File: rtl/rgb_pwm_pkg.sv
// Shared types, constants and helper functions for the RGB PWM board top.
package rgb_pwm_pkg;

    localparam int DUTY_W = 5;

    // Active-low seven-segment patterns, bit 0 = a ... bit 6 = g, bit 7 = dp (always off)
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Two decimal digits of a 0..31 duty value
    typedef struct packed {
        logic [1:0] tens;
        logic [3:0] units;
    } bcd_t;

    // Threshold-based conversion; the input never exceeds 31, so tens fits in 2 bits
    function automatic bcd_t bin5_to_bcd(input logic [DUTY_W-1:0] v);
        bcd_t r;
        if (v >= 5'd30) begin
            r.tens  = 2'd3;
            r.units = 4'(v - 5'd30);
        end else if (v >= 5'd20) begin
            r.tens  = 2'd2;
            r.units = 4'(v - 5'd20);
        end else if (v >= 5'd10) begin
            r.tens  = 2'd1;
            r.units = 4'(v - 5'd10);
        end else begin
            r.tens  = 2'd0;
            r.units = 4'(v);
        end
        return r;
    endfunction

    // Decimal digit to segment pattern; anything outside 0..9 shows blank
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rgb_pwm_top_pwm_channel.sv
// One PWM colour channel: period-start duty latch plus registered compare output.
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] cnt,
    input  logic              load,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              out,
    output logic [DUTY_W-1:0] duty
);

    logic [DUTY_W-1:0] duty_next;

    // The compare sees the freshly loaded duty on the period-start cycle, so a period never mixes two duties
    always_comb begin
        duty_next = load ? duty_in : duty;
    end

    // Duty latch and registered channel output
    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            out  <= 1'b0;
        end else begin
            duty <= duty_next;
            out  <= (cnt < duty_next);
        end
    end

endmodule

// File: rtl/rgb_pwm_top.sv
// Board top: switch-set 5-bit PWM on two RGB LEDs and a decimal duty readout on an 8-digit display.
module rgb_pwm_top
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_PRESCALE = 4,
    parameter int DIGIT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] SW,
    output logic [2:0]  LED0,
    output logic [2:0]  LED1,
    output logic [7:0]  CA,
    output logic [7:0]  AN
);

    localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int DIG_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_PRESCALE - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGIT_CYCLES - 1);

    logic [15:0]       sw_q;
    logic [PRE_W-1:0]  presc;
    logic [DUTY_W-1:0] pwm_cnt;
    logic              period_start;
    logic [DIG_W-1:0]  digit_timer;
    logic [2:0]        digit_idx;
    logic [DUTY_W-1:0] duty_r;
    logic [DUTY_W-1:0] duty_g;
    logic [DUTY_W-1:0] duty_b;
    logic              red_on;
    logic              green_on;
    logic              blue_on;
    bcd_t              bcd_r;
    bcd_t              bcd_g;
    bcd_t              bcd_b;
    logic [7:0]        seg_next;
    logic [7:0]        an_next;

    // Register the raw switches once so every consumer sees the same value
    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_q <= '0;
        end else begin
            sw_q <= SW;
        end
    end

    // Prescaler sets the PWM step length; the 5-bit step counter wraps naturally
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (presc == PRE_LAST) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign period_start = (pwm_cnt == '0) && (presc == '0);

    pwm_channel u_red (
        .clk     (CLK),
        .rst     (RST),
        .cnt     (pwm_cnt),
        .load    (period_start),
        .duty_in (sw_q[4:0]),
        .out     (red_on),
        .duty    (duty_r)
    );

    pwm_channel u_green (
        .clk     (CLK),
        .rst     (RST),
        .cnt     (pwm_cnt),
        .load    (period_start),
        .duty_in (sw_q[9:5]),
        .out     (green_on),
        .duty    (duty_g)
    );

    pwm_channel u_blue (
        .clk     (CLK),
        .rst     (RST),
        .cnt     (pwm_cnt),
        .load    (period_start),
        .duty_in (sw_q[14:10]),
        .out     (blue_on),
        .duty    (duty_b)
    );

    assign LED0 = {blue_on, green_on, red_on};
    assign LED1 = LED0 & {3{sw_q[15]}};

    // Digit timer holds each digit for DIGIT_CYCLES cycles, then steps the 3-bit index
    always_ff @(posedge CLK) begin
        if (RST) begin
            digit_timer <= '0;
            digit_idx   <= '0;
        end else if (digit_timer == DIG_LAST) begin
            digit_timer <= '0;
            digit_idx   <= digit_idx + 1'b1;
        end else begin
            digit_timer <= digit_timer + 1'b1;
        end
    end

    // Pick the segment pattern for the current digit from the latched duties
    always_comb begin
        bcd_r    = bin5_to_bcd(duty_r);
        bcd_g    = bin5_to_bcd(duty_g);
        bcd_b    = bin5_to_bcd(duty_b);
        seg_next = SEG_BLANK;
        case (digit_idx)
            3'd7:    seg_next = bcd_to_seg({2'b00, bcd_r.tens});
            3'd6:    seg_next = bcd_to_seg(bcd_r.units);
            3'd4:    seg_next = bcd_to_seg({2'b00, bcd_g.tens});
            3'd3:    seg_next = bcd_to_seg(bcd_g.units);
            3'd1:    seg_next = bcd_to_seg({2'b00, bcd_b.tens});
            3'd0:    seg_next = bcd_to_seg(bcd_b.units);
            default: seg_next = SEG_BLANK;
        endcase
        an_next = ~(8'b0000_0001 << digit_idx);
    end

    // Registered display drive; all digits dark while in reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            AN <= 8'hFF;
            CA <= 8'hFF;
        end else begin
            AN <= an_next;
            CA <= seg_next;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_top.sv
// Self-checking bench for rgb_pwm_top against a cycle-count based behavioural model.
module tb_rgb_pwm_top;

    localparam int P   = 4;
    localparam int D   = 1024;
    localparam int PER = 32 * P;

    logic        CLK;
    logic        RST;
    logic [15:0] SW;
    logic [2:0]  LED0;
    logic [2:0]  LED1;
    logic [7:0]  CA;
    logic [7:0]  AN;

    int n_cmp;
    int n_err;
    bit chk_en;

    // Reference model state: edges since reset release, registered switches, latched duties, expected outputs
    int          n;
    logic [15:0] m_swq;
    int          m_d [3];
    logic [2:0]  m_led0;
    logic [2:0]  m_led1;
    logic [7:0]  m_an;
    logic [7:0]  m_ca;
    logic [7:0]  seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int hi0 [3];
    int hi1 [3];

    rgb_pwm_top #(
        .PWM_PRESCALE (P),
        .DIGIT_CYCLES (D)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .SW   (SW),
        .LED0 (LED0),
        .LED1 (LED1),
        .CA   (CA),
        .AN   (AN)
    );

    // Free-running clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Decimal digit shown at a scan position, from the model's latched duties
    function automatic logic [7:0] digitSeg(input int idx);
        case (idx)
            7:       return seg_tab[m_d[0] / 10];
            6:       return seg_tab[m_d[0] % 10];
            4:       return seg_tab[m_d[1] / 10];
            3:       return seg_tab[m_d[1] % 10];
            1:       return seg_tab[m_d[2] / 10];
            0:       return seg_tab[m_d[2] % 10];
            default: return 8'hFF;
        endcase
    endfunction

    // One clock edge of the model: outputs follow from elapsed cycles since reset release
    task automatic modelEdge(input logic r, input logic [15:0] s);
        int idx;
        int stp;
        if (r) begin
            n      = 0;
            m_swq  = '0;
            m_d    = '{0, 0, 0};
            m_led0 = '0;
            m_an   = 8'hFF;
            m_ca   = 8'hFF;
        end else begin
            idx  = (n / D) % 8;
            m_an = ~(8'd1 << idx);
            m_ca = digitSeg(idx);
            if (n % PER == 0) begin
                m_d[0] = int'(m_swq[4:0]);
                m_d[1] = int'(m_swq[9:5]);
                m_d[2] = int'(m_swq[14:10]);
            end
            stp = (n % PER) / P;
            for (int c = 0; c < 3; c++) m_led0[c] = (stp < m_d[c]);
            m_swq = s;
            n++;
        end
        m_led1 = m_swq[15] ? m_led0 : 3'b000;
    endtask

    // Drive inputs, take one edge, advance the model and compare on the falling edge
    task automatic applyStimulus(input logic r, input logic [15:0] s);
        RST = r;
        SW  = s;
        @(posedge CLK);
        modelEdge(r, s);
        @(negedge CLK);
        if (chk_en) begin
            checkOutput("led0", 16'(LED0), 16'(m_led0));
            checkOutput("led1", 16'(LED1), 16'(m_led1));
            checkOutput("an",   16'(AN),   16'(m_an));
            checkOutput("ca",   16'(CA),   16'(m_ca));
        end
    endtask

    // Step until the next edge is a period start
    task automatic alignPeriod(input logic [15:0] s);
        while (n % PER != 0) applyStimulus(1'b0, s);
    endtask

    // Run one full period, counting high cycles per LED bit; optionally switch SW at a given cycle
    task automatic runPeriod(input logic [15:0] s0, input int change_at, input logic [15:0] s1);
        logic [15:0] s;
        s   = s0;
        hi0 = '{0, 0, 0};
        hi1 = '{0, 0, 0};
        for (int i = 0; i < PER; i++) begin
            if (i == change_at) s = s1;
            applyStimulus(1'b0, s);
            for (int c = 0; c < 3; c++) begin
                if (LED0[c]) hi0[c]++;
                if (LED1[c]) hi1[c]++;
            end
        end
    endtask

    initial begin
        logic [15:0] sw_a;
        logic [15:0] sw_bnd;
        logic [15:0] s;
        logic [7:0]  exp_ca [8];
        logic [7:0]  ca_cap;
        int          d;
        int          wait_cnt;
        int          hold;

        n_cmp  = 0;
        n_err  = 0;
        chk_en = 1'b1;
        n      = 0;
        m_swq  = '0;
        m_d    = '{0, 0, 0};
        RST    = 1'b1;
        SW     = 16'hFFFF;
        exp_ca = '{8'h92, 8'hF9, 8'hFF, 8'h80, 8'hA4, 8'hFF, 8'hB0, 8'hC0};

        $display("[TB] reset with all switches high");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'hFFFF);
            checkOutput("rst_led0", 16'(LED0), 16'h0);
            checkOutput("rst_led1", 16'(LED1), 16'h0);
            checkOutput("rst_an",   16'(AN),   16'hFF);
            checkOutput("rst_ca",   16'(CA),   16'hFF);
        end

        $display("[TB] duty ratios R=3 G=28 B=15");
        sw_a = 16'b0011111110000011;
        applyStimulus(1'b0, sw_a);
        checkOutput("first_an", 16'(AN), 16'hFE);
        alignPeriod(sw_a);
        runPeriod(sw_a, -1, sw_a);
        checkOutput("ratio_r",  16'(hi0[0]), 16'(3 * P));
        checkOutput("ratio_g",  16'(hi0[1]), 16'(28 * P));
        checkOutput("ratio_b",  16'(hi0[2]), 16'(15 * P));
        checkOutput("ratio_l1", 16'(hi1[0] + hi1[1] + hi1[2]), 16'h0);

        $display("[TB] display scan");
        for (int k = 0; k < 8; k++) begin
            d        = (k + 1) % 8;
            wait_cnt = 0;
            while (AN !== ~(8'd1 << d) && wait_cnt < 2 * D) begin
                applyStimulus(1'b0, sw_a);
                wait_cnt++;
            end
            checkOutput($sformatf("scan_wait%0d", d), 16'(wait_cnt < 2 * D), 16'h1);
            ca_cap = CA;
            hold   = 1;
            while (AN === ~(8'd1 << d) && hold < 2 * D) begin
                applyStimulus(1'b0, sw_a);
                if (AN === ~(8'd1 << d)) hold++;
            end
            checkOutput($sformatf("scan_ca%0d", d),   16'(ca_cap), 16'(exp_ca[d]));
            checkOutput($sformatf("scan_hold%0d", d), 16'(hold),   16'(D));
        end

        $display("[TB] randomized switch activity");
        for (int p = 0; p < 5; p++) begin
            s = 16'($urandom);
            for (int i = 0; i < PER; i++) begin
                if ($urandom_range(0, 15) == 0) s = 16'($urandom);
                applyStimulus(1'b0, s);
            end
        end

        $display("[TB] boundary duties R=0 G=31 B=31 with LED1 enabled");
        sw_bnd = {1'b1, 5'd31, 5'd31, 5'd0};
        applyStimulus(1'b0, sw_bnd);
        alignPeriod(sw_bnd);
        runPeriod(sw_bnd, -1, sw_bnd);
        checkOutput("bnd_r",    16'(hi0[0]), 16'h0);
        checkOutput("bnd_g",    16'(hi0[1]), 16'(31 * P));
        checkOutput("bnd_b",    16'(hi0[2]), 16'(31 * P));
        checkOutput("bnd_l1_r", 16'(hi1[0]), 16'h0);
        checkOutput("bnd_l1_g", 16'(hi1[1]), 16'(31 * P));
        checkOutput("bnd_l1_b", 16'(hi1[2]), 16'(31 * P));

        $display("[TB] mid-period duty change 3 -> 20");
        applyStimulus(1'b0, 16'd3);
        alignPeriod(16'd3);
        runPeriod(16'd3, 50, 16'd20);
        checkOutput("mid_cur",  16'(hi0[0]), 16'(3 * P));
        runPeriod(16'd20, -1, 16'd20);
        checkOutput("mid_next", 16'(hi0[0]), 16'(20 * P));

        $display("[TB] reset during scan");
        s = 16'hFFFF;
        for (int i = 0; i < 1500; i++) applyStimulus(1'b0, s);
        applyStimulus(1'b1, s);
        checkOutput("mrst_an",   16'(AN),   16'hFF);
        checkOutput("mrst_ca",   16'(CA),   16'hFF);
        checkOutput("mrst_led0", 16'(LED0), 16'h0);
        applyStimulus(1'b1, s);
        applyStimulus(1'b0, s);
        checkOutput("mrel_an",   16'(AN),   16'hFE);
        checkOutput("mrel_ca",   16'(CA),   16'hC0);
        checkOutput("mrel_led0", 16'(LED0), 16'h0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, s);
        checkOutput("mrel_hold", 16'(AN), 16'hFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
